turn_signal_input_conditioner: RTL

Front-end stage that directly feeds the tail-light sequencer FSM. It conditions the raw L/R turn switches: synchronises, debounces and latches them, and stretches short presses. It also divides the board clock into the slow step clock (SlowClk) that paces the sequencer. Outputs L_out/R_out change only on SlowClk falling edges, so the sequencer sees stable inputs for half a step period before each rising edge.

---
 rtl/turn_signal_input_conditioner.sv | 83 ++++++++
 1 files changed

// File: rtl/turn_signal_input_conditioner.sv
// rtl/turn_signal_input_conditioner.sv - sync/debounce/stretch of L/R turn switches plus step clock divider
module turn_signal_input_conditioner #(
  parameter int DB_CYCLES = 1000000,
  parameter int TICK_DIV  = 25000000,
  parameter int DB_W      = 20,
  parameter int DIV_W     = 25
) (
  input  logic Clk,
  input  logic Rst,
  input  logic L_raw,
  input  logic R_raw,
  output logic L_out,
  output logic R_out,
  output logic SlowClk,
  output logic Tick
);

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  // Index 0 is the left channel, index 1 the right channel.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      out_q, out_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];
  logic [DIV_W-1:0] div_q, div_d;
  logic            slow_q, tick_q;
  logic            wrap, update;

  assign wrap   = (div_q == DIV_MAX);
  // Outputs move only when SlowClk falls, giving the sequencer half a step of setup.
  assign update = wrap & slow_q;
  assign div_d  = wrap ? '0 : div_q + 1'b1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // A fresh rising edge outranks the clear so no press is ever lost.
      pend_d[i] = (deb_d[i] & ~deb_q[i]) | (pend_q[i] & ~update);
    end
    out_d = update ? (deb_q | pend_q) : out_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      div_q   <= '0;
      slow_q  <= 1'b0;
      tick_q  <= 1'b0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {R_raw, L_raw};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      div_q   <= div_d;
      tick_q  <= wrap;
      if (wrap) slow_q <= ~slow_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign L_out   = out_q[0];
  assign R_out   = out_q[1];
  assign SlowClk = slow_q;
  assign Tick    = tick_q;

endmodule
